mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 141 ++++++++++++++
 tb/tb_mc_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing and datapath strobes.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes; otherwise they retire as NOPs.
module mc_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        br_taken,
   output logic        mem_re,
   output logic        mem_we,
   output logic        ir_we,
   output logic        rf_we,
   output logic        pc_we,
   output logic [2:0]  imm_sel,
   output logic        alu_src_b,
   output logic [1:0]  wb_sel,
   output logic [1:0]  pc_sel,
   output logic        instr_done,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StTrap   = 3'd5
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpReg    = 7'b0110011;

   state_e     state_q;
   logic [6:0] opcode;
   logic       is_load, is_store, is_branch, is_jal, is_jalr, is_op, is_legal;
   logic [2:0] imm_dec;
   logic       unused_instr;

   assign opcode       = instr[6:0];
   assign unused_instr = ^instr[31:7];
   assign is_load      = (opcode == OpLoad);
   assign is_store     = (opcode == OpStore);
   assign is_branch    = (opcode == OpBranch);
   assign is_jal       = (opcode == OpJal);
   assign is_jalr      = (opcode == OpJalr);
   assign is_op        = (opcode == OpReg);
   assign is_legal     = is_load | is_store | is_branch | is_jal | is_jalr | is_op |
                         (opcode == OpImm) | (opcode == OpLui) | (opcode == OpAuipc);

   always_comb begin
      imm_dec = 3'd0;
      case (opcode)
         OpStore:        imm_dec = 3'd1;
         OpBranch:       imm_dec = 3'd2;
         OpJal:          imm_dec = 3'd3;
         OpLui, OpAuipc: imm_dec = 3'd4;
         default:        imm_dec = 3'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
      end else begin
         case (state_q)
            StFetch:  if (mem_ready) state_q <= StDecode;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            StDecode: state_q <= is_legal ? StExec : StTrap;
`else
            StDecode: state_q <= StExec;
`endif
            StExec: begin
               if (is_load || is_store)         state_q <= StMem;
               else if (is_branch || !is_legal) state_q <= StFetch;
               else                             state_q <= StWb;
            end
            StMem: begin
               if (mem_ready) state_q <= is_load ? StWb : StFetch;
            end
            StWb:    state_q <= StFetch;
            StTrap:  state_q <= StTrap;
            default: state_q <= StFetch;
         endcase
      end
   end

   // Outputs decode from the registered state; FETCH strobes are gated so reset shows all zeros.
   always_comb begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      rf_we     = 1'b0;
      pc_we     = 1'b0;
      imm_sel   = 3'd0;
      alu_src_b = 1'b0;
      wb_sel    = 2'd0;
      pc_sel    = 2'd0;
      if (state_q inside {StDecode, StExec, StMem, StWb}) begin
         imm_sel   = is_legal ? imm_dec : 3'd0;
         alu_src_b = is_legal && !is_op && !is_branch;
      end
      case (state_q)
         StFetch: begin
            mem_re = rst_n;
            ir_we  = rst_n & mem_ready;
         end
         StExec: begin
            if (is_branch) begin
               pc_we  = 1'b1;
               pc_sel = {1'b0, br_taken};
            end else if (!is_legal) begin
               pc_we = 1'b1;
            end
         end
         StMem: begin
            mem_re = is_load;
            mem_we = is_store;
            pc_we  = is_store & mem_ready;
         end
         StWb: begin
            rf_we  = 1'b1;
            pc_we  = 1'b1;
            wb_sel = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
            pc_sel = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
         end
         default: ;
      endcase
   end

   assign instr_done = pc_we;
   assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: driver pushes per-instruction expectations, monitor checks on instr_done.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        mem_ready = 1'b0;
   logic        br_taken = 1'b0;
   logic        mem_re, mem_we, ir_we, rf_we, pc_we, alu_src_b, instr_done;
   logic [2:0]  imm_sel, state;
   logic [1:0]  wb_sel, pc_sel;

   int checks = 0;
   int errors = 0;

   mc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
      .mem_re(mem_re), .mem_we(mem_we), .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we),
      .imm_sel(imm_sel), .alu_src_b(alu_src_b), .wb_sel(wb_sel), .pc_sel(pc_sel),
      .instr_done(instr_done), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lat; int rf; int mre; int mwe; int irw;
      int imm; int wb; int pcs; int alub; int st;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Whole-instruction summary derived from the opcode, wait counts and branch outcome.
   function automatic exp_t model(input logic [6:0] op, input int fw, input int mw, input logic bt);
      exp_t e;
      e.lat = fw + 4; e.rf = 1; e.mre = fw + 1; e.mwe = 0; e.irw = 1;
      e.imm = 0; e.wb = 0; e.pcs = 0; e.alub = 1; e.st = 4;
      case (op)
         7'b0000011: begin e.lat = fw + mw + 5; e.mre = fw + mw + 2; e.wb = 1; end
         7'b0100011: begin e.lat = fw + mw + 4; e.mwe = mw + 1; e.rf = 0; e.imm = 1; e.st = 3; end
         7'b1100011: begin e.lat = fw + 3; e.rf = 0; e.imm = 2; e.alub = 0; e.pcs = int'(bt); e.st = 2; end
         7'b1101111: begin e.imm = 3; e.wb = 2; e.pcs = 1; end
         7'b1100111: begin e.wb = 2; e.pcs = 2; end
         7'b0110111, 7'b0010111: e.imm = 4;
         7'b0110011: e.alub = 0;
         7'b0010011: ;
         default: begin e.lat = fw + 3; e.rf = 0; e.alub = 0; e.st = 2; end
      endcase
      return e;
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                        7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011};
   endfunction

   // Called at posedge+#1 at the start of the instruction's first FETCH cycle.
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic bt);
      exp_t e;
      bit   is_mem;
      e = model(ins[6:0], fw, mw, bt);
      is_mem = (ins[6:0] == 7'b0000011) || (ins[6:0] == 7'b0100011);
      q.push_back(e);
      instr = ins;
      br_taken = bt;
      for (int k = 0; k < e.lat; k++) begin
         if (k < fw)                                        mem_ready = 1'b0;
         else if (k == fw)                                  mem_ready = 1'b1;
         else if (is_mem && k >= fw + 3 && k < fw + 3 + mw) mem_ready = 1'b0;
         else if (is_mem && k == fw + 3 + mw)               mem_ready = 1'b1;
         else                                               mem_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
   endtask

   int cyc = 0, n_mre = 0, n_mwe = 0, n_rf = 0, n_ir = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         cyc = 0; n_mre = 0; n_mwe = 0; n_rf = 0; n_ir = 0;
      end else begin
         exp_t e;
         cyc++;
         n_mre += int'(mem_re);
         n_mwe += int'(mem_we);
         n_rf  += int'(rf_we);
         n_ir  += int'(ir_we);
         if (mem_re && mem_we) chk("re_we_exclusive", 1, 0);
         if (instr_done != pc_we) chk("done_eq_pcwe", int'(instr_done), int'(pc_we));
         if (instr_done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = q.pop_front();
               chk("latency", cyc, e.lat);
               chk("rf_we_cycles", n_rf, e.rf);
               chk("mem_re_cycles", n_mre, e.mre);
               chk("mem_we_cycles", n_mwe, e.mwe);
               chk("ir_we_cycles", n_ir, e.irw);
               chk("imm_sel", int'(imm_sel), e.imm);
               chk("wb_sel", int'(wb_sel), e.wb);
               chk("pc_sel", int'(pc_sel), e.pcs);
               chk("alu_src_b", int'(alu_src_b), e.alub);
               chk("done_state", int'(state), e.st);
            end
            cyc = 0; n_mre = 0; n_mwe = 0; n_rf = 0; n_ir = 0;
         end
      end
   end

   localparam logic [6:0] OPS [9] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                                      7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
                                      7'b0110011};

   initial begin
      logic [31:0] r;
      logic [6:0]  op;

      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_state", int'(state), 0);
      chk("reset_mem_re", int'(mem_re), 0);
      chk("reset_ir_we", int'(ir_we), 0);
      chk("reset_pc_we", int'(pc_we), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("post_reset_mem_re", int'(mem_re), 1);

      run_instr(32'h002081B3, 0, 0, 1'b0);
      run_instr(32'h0040A103, 0, 2, 1'b0);
      run_instr(32'h00208463, 0, 0, 1'b1);
      run_instr(32'h00208463, 1, 0, 1'b0);
      run_instr(32'h008000EF, 0, 0, 1'b0);
      run_instr(32'h000080E7, 2, 0, 1'b1);

      // Store interrupted by an asynchronous reset while waiting in MEM.
      instr = 32'h0020A023;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 mem_ready = 1'b0;
      @(posedge clk); #1;
      #2 chk("store_in_mem", int'(state), 3);
      chk("store_mem_we", int'(mem_we), 1);
      rst_n = 1'b0;
      #1 chk("async_reset_state", int'(state), 0);
      chk("async_reset_mem_we", int'(mem_we), 0);
      chk("async_reset_pc_we", int'(pc_we), 0);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      run_instr(32'h0020A023, 0, 1, 1'b0);

      for (int i = 0; i < 300; i++) begin
         r = $urandom();
         if ($urandom_range(0, 9) == 0) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            op = OPS[$urandom_range(0, 8)];
`else
            op = r[6:0];
            while (is_legal(op)) op = 7'($urandom());
`endif
         end else begin
            op = OPS[$urandom_range(0, 8)];
         end
         run_instr({r[31:7], op}, $urandom_range(0, 2), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
      end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      instr = 32'h0000007F;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("trap_state", int'(state), 5);
         chk("trap_pc_we", int'(pc_we), 0);
      end
`else
      run_instr(32'h0000007F, 0, 0, 1'b0);
`endif

      repeat (2) @(posedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
